keypad_emulator: RTL and testbench

//  Responder side of the 4x4 matrix-keypad interface. It stands in for the physical keypad so the

---
 rtl/keypad_emulator.sv | 142 ++++++++++++++
 tb/tb_keypad_emulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Stands in for a 4x4 matrix keypad: queued key codes are replayed as timed presses
// (optional bounce, hold, release gap) that answer the scanner's row drive on the columns.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned GAP_CYCLES    = 1000,
  parameter int unsigned BOUNCE_CYCLES = 0,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_code,
  output logic       o_key_ready,
  input  logic [3:0] i_rows,
  output logic [3:0] o_cols,
  output logic       o_key_active,
  output logic       o_busy,
  output logic       o_done_pulse
);

  localparam int unsigned HoldGap = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntMax  = (BOUNCE_CYCLES > HoldGap) ? BOUNCE_CYCLES : HoldGap;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);

  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] BounceLast = CntW'(BOUNCE_CYCLES - 1);
  localparam logic [PtrW:0]   PtrOne     = (PtrW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StBounce, StHold, StGap} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic [3:0]      r_cur_key;
  logic [3:0]      r_cols;
  logic [3:0]      w_cols_next;
  logic            w_pressed;
  logic            w_pop;
  logic            w_done;

  logic [3:0]  r_fifo [FIFO_DEPTH];
  logic [PtrW:0] r_wr_ptr;
  logic [PtrW:0] r_rd_ptr;
  logic          w_full;
  logic          w_empty;
  logic          w_push;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                   (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
  assign w_push  = i_key_valid && !w_full;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[PtrW-1:0]] <= i_key_code;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_cur_key <= 4'h0;
      r_cols    <= 4'hF;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_cols  <= w_cols_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PtrOne;
        r_cur_key <= r_fifo[r_rd_ptr[PtrW-1:0]];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CntOne;
    w_pressed    = 1'b0;
    w_pop        = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = (BOUNCE_CYCLES > 0) ? StBounce : StHold;
        end
      end
      StBounce: begin
        w_pressed = ~r_cnt[0];
        if (r_cnt == BounceLast) begin
          w_state_next = StHold;
          w_cnt_next   = '0;
        end
      end
      StHold: begin
        w_pressed = 1'b1;
        if (r_cnt == HoldLast) begin
          w_state_next = StGap;
          w_cnt_next   = '0;
        end
      end
      StGap: begin
        if (r_cnt == GapLast) begin
          w_done       = 1'b1;
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  // The key answers whenever its own row is among those driven low.
  always_comb begin
    w_cols_next = 4'hF;
    if (w_pressed && !i_rows[r_cur_key[3:2]]) begin
      w_cols_next[r_cur_key[1:0]] = 1'b0;
    end
  end

  assign o_key_ready  = !w_full;
  assign o_cols       = r_cols;
  assign o_key_active = (r_state == StBounce) || (r_state == StHold);
  assign o_busy       = (r_state != StIdle) || !w_empty;
  assign o_done_pulse = w_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: one instance without bounce, one with 4 bounce cycles.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, b_valid;
  logic [3:0] a_code, b_code;
  logic [3:0] a_rows, b_rows;
  logic       a_ready, b_ready;
  logic [3:0] a_cols, b_cols;
  logic       a_active, b_active;
  logic       a_busy, b_busy;
  logic       a_done, b_done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES(8), .GAP_CYCLES(8), .BOUNCE_CYCLES(0), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_key_valid(a_valid), .i_key_code(a_code),
    .o_key_ready(a_ready), .i_rows(a_rows), .o_cols(a_cols), .o_key_active(a_active),
    .o_busy(a_busy), .o_done_pulse(a_done)
  );

  keypad_emulator #(
    .HOLD_CYCLES(8), .GAP_CYCLES(8), .BOUNCE_CYCLES(4), .FIFO_DEPTH(4)
  ) dut_b (
    .i_clk(clk), .i_reset(reset), .i_key_valid(b_valid), .i_key_code(b_code),
    .o_key_ready(b_ready), .i_rows(b_rows), .o_cols(b_cols), .o_key_active(b_active),
    .o_busy(b_busy), .o_done_pulse(b_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      seen = a_done;
    end
    chk(tag, {7'd0, seen}, 8'd1);
  endtask

  task automatic wait_active_a(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      step();
      seen = a_active;
    end
    chk(tag, {7'd0, seen}, 8'd1);
  endtask

  logic [3:0] pat3 [4];
  logic [3:0] keys4 [4];
  logic [3:0] cols4 [4];
  logic [3:0] exp5 [12];
  bit bad_cols, bad_done, bad_active;

  initial begin
    pat3  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    keys4 = '{4'h3, 4'h6, 4'h9, 4'hF};
    cols4 = '{4'b0111, 4'b1011, 4'b1101, 4'b0111};
    exp5  = '{4'b1110, 4'b1111, 4'b1110, 4'b1111, 4'b1110, 4'b1110,
              4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110};
    reset = 1'b1;
    a_valid = 1'b0; a_code = 4'h0; a_rows = 4'hF;
    b_valid = 1'b0; b_code = 4'h0; b_rows = 4'hF;

    // Reset state
    step(); step();
    chk("rst_cols", {4'h0, a_cols}, 8'h0F);
    chk("rst_ready", {7'd0, a_ready}, 8'd1);
    chk("rst_busy", {7'd0, a_busy}, 8'd0);
    chk("rst_active", {7'd0, a_active}, 8'd0);
    chk("rst_done", {7'd0, a_done}, 8'd0);
    chk("rst_b_cols", {4'h0, b_cols}, 8'h0F);
    reset = 1'b0;

    // Single press of key 0x0 with row 0 held low
    a_valid = 1'b1; a_code = 4'h0; a_rows = 4'b1110;
    step();
    a_valid = 1'b0;
    chk("t2_active_e0", {7'd0, a_active}, 8'd0);
    chk("t2_busy_e0", {7'd0, a_busy}, 8'd1);
    step();
    chk("t2_active_e1", {7'd0, a_active}, 8'd1);
    chk("t2_cols_e1", {4'h0, a_cols}, 8'h0F);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_cols_hold", {4'h0, a_cols}, 8'h0E);
    end
    step();
    chk("t2_cols_gap", {4'h0, a_cols}, 8'h0F);
    chk("t2_active_gap", {7'd0, a_active}, 8'd0);
    repeat (5) step();
    chk("t2_done_early", {7'd0, a_done}, 8'd0);
    step();
    chk("t2_done", {7'd0, a_done}, 8'd1);
    chk("t2_busy_done", {7'd0, a_busy}, 8'd1);
    step();
    chk("t2_done_after", {7'd0, a_done}, 8'd0);
    chk("t2_busy_after", {7'd0, a_busy}, 8'd0);

    // Key 0x6 against a rotating row scan
    a_valid = 1'b1; a_code = 4'h6; a_rows = 4'hF;
    step();
    a_valid = 1'b0;
    step();
    chk("t3_active", {7'd0, a_active}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      a_rows = pat3[i % 4];
      step();
      chk("t3_cols", {4'h0, a_cols}, (pat3[i % 4] == 4'b1101) ? 8'h0B : 8'h0F);
    end
    a_rows = 4'hF;
    wait_done_a("t3_done");
    step();
    chk("t3_busy_after", {7'd0, a_busy}, 8'd0);

    // Fill the queue while a key is held, then an overflow push
    a_valid = 1'b1; a_code = 4'h0;
    step();
    a_valid = 1'b0;
    step();
    chk("t4_active", {7'd0, a_active}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_code = keys4[i];
      step();
      chk("t4_ready", {7'd0, a_ready}, (i == 3) ? 8'd0 : 8'd1);
    end
    a_code = 4'h1;
    step();
    a_valid = 1'b0;
    chk("t4_ready_ovf", {7'd0, a_ready}, 8'd0);
    a_rows = 4'b0000;
    wait_done_a("t4_done_k0");
    for (int i = 0; i < 4; i++) begin
      wait_active_a("t4_active_k");
      step();
      chk("t4_cols_k", {4'h0, a_cols}, {4'h0, cols4[i]});
      wait_done_a("t4_done_k");
    end
    step();
    chk("t4_busy_end", {7'd0, a_busy}, 8'd0);
    chk("t4_active_end", {7'd0, a_active}, 8'd0);

    // Bounce on the second instance
    b_valid = 1'b1; b_code = 4'h0; b_rows = 4'b1110;
    step();
    b_valid = 1'b0;
    step();
    chk("t5_active", {7'd0, b_active}, 8'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t5_cols", {4'h0, b_cols}, {4'h0, exp5[i]});
    end
    step();
    chk("t5_cols_gap", {4'h0, b_cols}, 8'h0F);

    // Reset in the middle of a hold with two keys queued
    a_valid = 1'b1; a_code = 4'h0; a_rows = 4'b1110;
    step();
    a_valid = 1'b0;
    step();
    chk("t6_active", {7'd0, a_active}, 8'd1);
    a_valid = 1'b1; a_code = 4'h6;
    step();
    a_code = 4'h9;
    step();
    a_valid = 1'b0;
    step();
    chk("t6_cols_pre", {4'h0, a_cols}, 8'h0E);
    reset = 1'b1;
    step();
    chk("t6_cols_rst", {4'h0, a_cols}, 8'h0F);
    chk("t6_busy_rst", {7'd0, a_busy}, 8'd0);
    chk("t6_active_rst", {7'd0, a_active}, 8'd0);
    chk("t6_done_rst", {7'd0, a_done}, 8'd0);
    chk("t6_ready_rst", {7'd0, a_ready}, 8'd1);
    reset = 1'b0;
    a_rows = 4'b0000;
    bad_cols = 1'b0; bad_done = 1'b0; bad_active = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (a_cols != 4'hF) bad_cols = 1'b1;
      if (a_done) bad_done = 1'b1;
      if (a_active) bad_active = 1'b1;
    end
    chk("t6_no_press", {7'd0, bad_cols}, 8'd0);
    chk("t6_no_done", {7'd0, bad_done}, 8'd0);
    chk("t6_no_active", {7'd0, bad_active}, 8'd0);
    chk("t6_busy_end", {7'd0, a_busy}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
